// File: rtl/capture_pkg.sv
// Shared definitions for the capture / Sobel datapath: state encodings,
// frame geometry and the default Sobel watchdog budget.
package capture_pkg;

  localparam int unsigned FRAME_PIXELS_DEFAULT   = 307200;  // 640x480
  localparam int unsigned FRAME_LAST_ADDR        = FRAME_PIXELS_DEFAULT - 1;
  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 1048576;

  localparam int unsigned ADDR_W = 19;
  localparam int unsigned WD_W   = 20;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_ARM     = 3'd1;
  localparam state_t ST_CAPTURE = 3'd2;
  localparam state_t ST_FILTER  = 3'd3;
  localparam state_t ST_DONE    = 3'd4;

endpackage

// File: rtl/frame_edge_detect.sv
// Button rising-edge and end-of-frame detection for the capture sequencer.
// eof fires once, on the first cycle the camera address reaches the last pixel.
module frame_edge_detect
  import capture_pkg::*;
#(
  parameter int unsigned FRAME_PIXELS = FRAME_PIXELS_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              snap_req,
  input  logic [ADDR_W-1:0] capture_addr,
  output logic              snap_rise,
  output logic              eof
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(FRAME_PIXELS - 1);

  logic              snap_req_q;
  logic [ADDR_W-1:0] prev_addr_q;

  // Delay the button level and the camera address by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      snap_req_q  <= 1'b0;
      prev_addr_q <= '0;
    end else begin
      snap_req_q  <= snap_req;
      prev_addr_q <= capture_addr;
    end
  end

  assign snap_rise = snap_req & ~snap_req_q;
  // A held last address must not retrigger, so qualify with the previous address.
  assign eof       = (capture_addr == LastAddr) && (prev_addr_q != LastAddr);

endmodule

// File: rtl/capture_sequencer.sv
// Snapshot sequencer: waits for a frame boundary, gates one full frame into the
// static BRAM, kicks off a Sobel pass and supervises it with a watchdog.
module capture_sequencer
  import capture_pkg::*;
#(
  parameter int unsigned FRAME_PIXELS   = FRAME_PIXELS_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              snap_req,
  input  logic              continuous,
  input  logic [ADDR_W-1:0] capture_addr,
  input  logic              sobel_done,
  output logic              static_we,
  output logic              sobel_start,
  output logic              busy,
  output logic [2:0]        state_dbg,
  output logic              error,
  output logic [7:0]        frame_count
);

  localparam logic [WD_W-1:0] WdLast = WD_W'(TIMEOUT_CYCLES - 1);

  state_t          state_q, state_d;
  logic            static_we_q, sobel_start_q, error_q;
  logic [WD_W-1:0] wd_q;
  logic [7:0]      frame_count_q;
  logic            snap_rise, eof, timeout;

  frame_edge_detect #(
    .FRAME_PIXELS (FRAME_PIXELS)
  ) u_edge (
    .clk          (clk),
    .reset        (reset),
    .snap_req     (snap_req),
    .capture_addr (capture_addr),
    .snap_rise    (snap_rise),
    .eof          (eof)
  );

  // Next-state logic; sobel_done takes priority over a simultaneous timeout.
  always_comb begin
    state_d = state_q;
    timeout = 1'b0;
    case (state_q)
      ST_IDLE:    if (snap_rise || continuous) state_d = ST_ARM;
      ST_ARM:     if (eof) state_d = ST_CAPTURE;
      ST_CAPTURE: if (eof) state_d = ST_FILTER;
      ST_FILTER: begin
        if (sobel_done) begin
          state_d = ST_DONE;
        end else if (wd_q == WdLast) begin
          state_d = ST_IDLE;
          timeout = 1'b1;
        end
      end
      ST_DONE:    state_d = continuous ? ST_ARM : ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // State, registered outputs, watchdog and pass counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      static_we_q   <= 1'b0;
      sobel_start_q <= 1'b0;
      error_q       <= 1'b0;
      wd_q          <= '0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      static_we_q   <= (state_d == ST_CAPTURE);
      sobel_start_q <= (state_q == ST_CAPTURE) && (state_d == ST_FILTER);
      // Zero outside FILTER so the first FILTER cycle sees 0.
      wd_q          <= (state_q == ST_FILTER) ? wd_q + 1'b1 : '0;
      if (timeout) begin
        error_q <= 1'b1;
      end else if ((state_q == ST_IDLE) && (state_d == ST_ARM)) begin
        error_q <= 1'b0;
      end
      if (state_q == ST_DONE) frame_count_q <= frame_count_q + 8'd1;
    end
  end

  assign static_we   = static_we_q;
  assign sobel_start = sobel_start_q;
  assign busy        = (state_q != ST_IDLE);
  assign state_dbg   = state_q;
  assign error       = error_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed bench for capture_sequencer with a 16-pixel frame and a 64-cycle
// watchdog; the camera address advances one pixel every two clocks.
module tb_capture_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        snap_req;
  logic        continuous;
  logic [18:0] capture_addr;
  logic        sobel_done;
  logic        static_we;
  logic        sobel_start;
  logic        busy;
  logic [2:0]  state_dbg;
  logic        error;
  logic [7:0]  frame_count;

  int errors = 0;
  int checks = 0;

  logic gen_en = 1'b0;
  logic sub    = 1'b0;

  capture_sequencer #(
    .FRAME_PIXELS   (16),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .snap_req     (snap_req),
    .continuous   (continuous),
    .capture_addr (capture_addr),
    .sobel_done   (sobel_done),
    .static_we    (static_we),
    .sobel_start  (sobel_start),
    .busy         (busy),
    .state_dbg    (state_dbg),
    .error        (error),
    .frame_count  (frame_count)
  );

  initial forever #5 clk = ~clk;

  // One clock; outputs are sampled 1 time unit after the edge, then the
  // address sweep advances (each address is held for two clocks).
  task automatic step();
    @(posedge clk);
    #1;
    if (gen_en) begin
      if (sub) begin
        capture_addr = (capture_addr == 19'd15) ? 19'd0 : capture_addr + 19'd1;
        sub = 1'b0;
      end else begin
        sub = 1'b1;
      end
    end
  endtask

  task automatic snap_edge();
    snap_req = 1'b0;
    step();
    snap_req = 1'b1;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1; snap_req = 1'b0; continuous = 1'b0; sobel_done = 1'b0;
    capture_addr = 19'd0;
    step(); step();
    checks++;
    if ({static_we, sobel_start, busy, state_dbg, error, frame_count} !== 15'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b required 0", {static_we, sobel_start, busy,
               state_dbg, error, frame_count});
    end
    reset = 1'b0;
    step();
    checks++;
    if (state_dbg !== 3'd0) begin
      errors++; $display("FAIL reset_idle: got %0d required 0", state_dbg);
    end
  endtask

  task automatic test_single();
    int n;
    gen_en = 1'b1;
    n = 0;
    while (capture_addr != 19'd5 && n < 100) begin step(); n++; end
    snap_edge();
    checks++;
    if (state_dbg !== 3'd1 || busy !== 1'b1) begin
      errors++; $display("FAIL single_arm: got state %0d busy %0d required 1 1", state_dbg, busy);
    end
    snap_req = 1'b0;
    n = 0;
    while (static_we !== 1'b1 && n < 100) begin step(); n++; end
    checks++;
    if (n >= 100 || state_dbg !== 3'd2 || capture_addr !== 19'd15) begin
      errors++; $display("FAIL single_capture_start: got state %0d addr %0d required 2 15",
                         state_dbg, capture_addr);
    end
    n = 0;
    while (static_we === 1'b1 && n < 100) begin step(); n++; end
    checks++;
    if (n !== 32) begin
      errors++; $display("FAIL single_we_cycles: got %0d required 32", n);
    end
    checks++;
    if (sobel_start !== 1'b1 || state_dbg !== 3'd3) begin
      errors++; $display("FAIL single_sobel_start: got start %0d state %0d required 1 3",
                         sobel_start, state_dbg);
    end
    step();
    checks++;
    if (sobel_start !== 1'b0) begin
      errors++; $display("FAIL single_start_pulse: got %0d required 0", sobel_start);
    end
    repeat (8) step();
    sobel_done = 1'b1;
    step();
    sobel_done = 1'b0;
    checks++;
    if (state_dbg !== 3'd4) begin
      errors++; $display("FAIL single_done: got %0d required 4", state_dbg);
    end
    step();
    checks++;
    if (state_dbg !== 3'd0 || busy !== 1'b0 || frame_count !== 8'd1) begin
      errors++; $display("FAIL single_end: got state %0d busy %0d count %0d required 0 0 1",
                         state_dbg, busy, frame_count);
    end
  endtask

  task automatic test_continuous();
    int n;
    int idle_seen;
    idle_seen = 0;
    continuous = 1'b1;
    step();
    for (int p = 0; p < 3; p++) begin
      n = 0;
      while (sobel_start !== 1'b1 && n < 200) begin
        step(); n++;
        if (busy !== 1'b1) idle_seen++;
      end
      checks++;
      if (n >= 200) begin
        errors++; $display("FAIL cont_start_timeout: pass %0d got no sobel_start", p);
      end
      if (p == 2) continuous = 1'b0;
      repeat (4) begin
        step();
        if (busy !== 1'b1) idle_seen++;
      end
      sobel_done = 1'b1;
      step();
      sobel_done = 1'b0;
      checks++;
      if (state_dbg !== 3'd4) begin
        errors++; $display("FAIL cont_done: pass %0d got %0d required 4", p, state_dbg);
      end
      if (p < 2) begin
        step();
        if (busy !== 1'b1) idle_seen++;
      end
    end
    checks++;
    if (idle_seen !== 0) begin
      errors++; $display("FAIL cont_busy: got %0d idle cycles required 0", idle_seen);
    end
    step();
    checks++;
    if (state_dbg !== 3'd0 || frame_count !== 8'd4) begin
      errors++; $display("FAIL cont_end: got state %0d count %0d required 0 4",
                         state_dbg, frame_count);
    end
  endtask

  task automatic test_timeout();
    int n;
    snap_edge();
    n = 0;
    while (sobel_start !== 1'b1 && n < 200) begin step(); n++; end
    n = 0;
    while (state_dbg === 3'd3 && n < 200) begin step(); n++; end
    checks++;
    if (n !== 64) begin
      errors++; $display("FAIL timeout_cycles: got %0d required 64", n);
    end
    checks++;
    if (state_dbg !== 3'd0 || error !== 1'b1) begin
      errors++; $display("FAIL timeout_state: got state %0d error %0d required 0 1",
                         state_dbg, error);
    end
    repeat (3) step();
    checks++;
    if (error !== 1'b1 || frame_count !== 8'd4) begin
      errors++; $display("FAIL timeout_sticky: got error %0d count %0d required 1 4",
                         error, frame_count);
    end
    snap_edge();
    checks++;
    if (state_dbg !== 3'd1 || error !== 1'b0) begin
      errors++; $display("FAIL timeout_clear: got state %0d error %0d required 1 0",
                         state_dbg, error);
    end
  endtask

  task automatic test_ignored();
    int n;
    n = 0;
    while (state_dbg !== 3'd2 && n < 100) begin step(); n++; end
    snap_edge();
    checks++;
    if (state_dbg !== 3'd2) begin
      errors++; $display("FAIL ignore_snap_capture: got %0d required 2", state_dbg);
    end
    n = 0;
    while (sobel_start !== 1'b1 && n < 100) begin step(); n++; end
    sobel_done = 1'b1;
    step();
    sobel_done = 1'b0;
    step();
    checks++;
    if (state_dbg !== 3'd0 || frame_count !== 8'd5) begin
      errors++; $display("FAIL ignore_pass_end: got state %0d count %0d required 0 5",
                         state_dbg, frame_count);
    end
    repeat (3) step();
    checks++;
    if (state_dbg !== 3'd0) begin
      errors++; $display("FAIL ignore_not_queued: got %0d required 0", state_dbg);
    end
    sobel_done = 1'b1;
    step();
    sobel_done = 1'b0;
    step();
    checks++;
    if (state_dbg !== 3'd0 || frame_count !== 8'd5) begin
      errors++; $display("FAIL ignore_done_idle: got state %0d count %0d required 0 5",
                         state_dbg, frame_count);
    end
  endtask

  task automatic test_reset_mid_capture();
    int n;
    snap_edge();
    n = 0;
    while (!(static_we === 1'b1 && capture_addr == 19'd7) && n < 100) begin step(); n++; end
    reset = 1'b1;
    step();
    checks++;
    if (static_we !== 1'b0 || state_dbg !== 3'd0 || frame_count !== 8'd0 || n >= 100) begin
      errors++; $display("FAIL reset_mid_capture: got we %0d state %0d count %0d required 0 0 0",
                         static_we, state_dbg, frame_count);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_boundary();
    int n;
    snap_edge();
    n = 0;
    while (sobel_start !== 1'b1 && n < 100) begin step(); n++; end
    repeat (63) step();
    sobel_done = 1'b1;
    step();
    sobel_done = 1'b0;
    checks++;
    if (state_dbg !== 3'd4 || error !== 1'b0) begin
      errors++; $display("FAIL same_cycle_done: got state %0d error %0d required 4 0",
                         state_dbg, error);
    end
    step();
    checks++;
    if (frame_count !== 8'd1) begin
      errors++; $display("FAIL same_cycle_count: got %0d required 1", frame_count);
    end
    // Held last address: one eof only.
    gen_en = 1'b0;
    capture_addr = 19'd3;
    snap_edge();
    capture_addr = 19'd15;
    step();
    checks++;
    if (state_dbg !== 3'd2) begin
      errors++; $display("FAIL hold_first_eof: got %0d required 2", state_dbg);
    end
    repeat (3) step();
    checks++;
    if (state_dbg !== 3'd2) begin
      errors++; $display("FAIL hold_single_eof: got %0d required 2", state_dbg);
    end
    capture_addr = 19'd14;
    step();
    capture_addr = 19'd15;
    step();
    checks++;
    if (state_dbg !== 3'd3 || sobel_start !== 1'b1) begin
      errors++; $display("FAIL hold_rearm_eof: got state %0d start %0d required 3 1",
                         state_dbg, sobel_start);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_continuous();
    test_timeout();
    test_ignored();
    test_reset_mid_capture();
    test_boundary();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
